reg_writeback_queue: RTL and testbench

- Buffered writer in front of the register-file write port (regwrite/rd/write_data).
- Accepts writeback requests from variable-latency producers (ALU, load unit) through a valid/ready handshake and drains them in order, one per cycle, into the register file.
- Provides a combinational bypass lookup for two read addresses, so ID-stage reads see values that are queued but not yet written.

---
 rtl/reg_writeback_queue_pkg.sv | 15 +
 rtl/reg_writeback_queue_fwd_match.sv | 25 ++
 rtl/reg_writeback_queue.sv | 112 +++++++++++
 tb/tb_reg_writeback_queue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_queue_pkg.sv
// Shared widths, default depth and queue entry layout for the writeback queue.
package reg_writeback_queue_pkg;

  localparam int unsigned RS_WIDTH       = 5;
  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam int unsigned WBQ_DEPTH      = 4;

  // One queued register-file write.
  typedef struct packed {
    logic                      valid;
    logic [RS_WIDTH-1:0]       rd;
    logic [REG_DATA_WIDTH-1:0] data;
  } wbq_entry_t;

endpackage

// File: rtl/reg_writeback_queue_fwd_match.sv
// Youngest-match priority search over the queued entries (combinational).
module wbq_fwd_match
  import reg_writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH = WBQ_DEPTH
) (
  input  wbq_entry_t [DEPTH-1:0]    entries_yf,  // index 0 is the youngest entry
  input  logic [RS_WIDTH-1:0]       rs,
  output logic                      hit,
  output logic [REG_DATA_WIDTH-1:0] data
);

  // Walk oldest to youngest so the youngest match overwrites older ones; x0 never hits.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (entries_yf[DEPTH-1-k].valid && (entries_yf[DEPTH-1-k].rd == rs) && (rs != '0)) begin
        hit  = 1'b1;
        data = entries_yf[DEPTH-1-k].data;
      end
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// In-order buffered writer in front of the register-file write port, with bypass lookup.
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = WBQ_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_valid,
  output logic                      push_ready,
  input  logic [RS_WIDTH-1:0]       push_rd,
  input  logic [REG_DATA_WIDTH-1:0] push_data,
  input  logic                      drain_en,
  output logic                      regwrite,
  output logic [RS_WIDTH-1:0]       rd,
  output logic [REG_DATA_WIDTH-1:0] write_data,
  input  logic [RS_WIDTH-1:0]       rs1,
  input  logic [RS_WIDTH-1:0]       rs2,
  output logic                      fwd1_hit,
  output logic                      fwd2_hit,
  output logic [REG_DATA_WIDTH-1:0] fwd1_data,
  output logic [REG_DATA_WIDTH-1:0] fwd2_data,
  output logic [PTR_W:0]            count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  wbq_entry_t [DEPTH-1:0] mem_q, mem_d;
  wbq_entry_t [DEPTH-1:0] age_view;
  logic [CNT_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_d;
  logic                   ready_q, ready_d;
  logic [PTR_W-1:0]       wr_idx, rd_idx;
  logic                   empty, push_fire, enq, pop;

  assign wr_idx     = wr_ptr_q[PTR_W-1:0];
  assign rd_idx     = rd_ptr_q[PTR_W-1:0];
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign count      = wr_ptr_q - rd_ptr_q;
  assign push_ready = ready_q;

  // Head entry drives the register-file port; zeros while empty.
  always_comb begin
    regwrite   = !empty && drain_en;
    rd         = '0;
    write_data = '0;
    if (!empty) begin
      rd         = mem_q[rd_idx].rd;
      write_data = mem_q[rd_idx].data;
    end
  end

  // Next-state: enqueue non-x0 transfers, retire the head on a write, track readiness.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    push_fire = push_valid && ready_q;
    enq       = push_fire && (push_rd != '0);
    pop       = regwrite;
    if (pop) begin
      mem_d[rd_idx].valid = 1'b0;
      rd_ptr_d            = rd_ptr_q + CNT_W'(1);
    end
    if (enq) begin
      mem_d[wr_idx] = '{valid: 1'b1, rd: push_rd, data: push_data};
      wr_ptr_d      = wr_ptr_q + CNT_W'(1);
    end
    count_d = wr_ptr_d - rd_ptr_d;
    ready_d = (count_d != CNT_W'(DEPTH));
  end

  // State registers; reset discards every queued entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
    end
  end

  // Reorder storage youngest-first for the bypass search.
  always_comb begin
    age_view = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      age_view[k] = mem_q[wr_idx - PTR_W'(k + 1)];
    end
  end

  wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries_yf (age_view),
    .rs         (rs1),
    .hit        (fwd1_hit),
    .data       (fwd1_data)
  );

  wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries_yf (age_view),
    .rs         (rs2),
    .hit        (fwd2_hit),
    .data       (fwd2_data)
  );

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench for reg_writeback_queue: driver queues expected writes, monitor checks the port.
module tb_reg_writeback_queue;
  import reg_writeback_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  typedef struct packed {
    logic [RS_WIDTH-1:0]       rd;
    logic [REG_DATA_WIDTH-1:0] data;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      push_valid, push_ready, drain_en, regwrite;
  logic [RS_WIDTH-1:0]       push_rd, rd, rs1, rs2;
  logic [REG_DATA_WIDTH-1:0] push_data, write_data, fwd1_data, fwd2_data;
  logic                      fwd1_hit, fwd2_hit;
  logic [PTR_W:0]            count;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  logic [REG_DATA_WIDTH-1:0] rf [32];

  reg_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready), .push_rd(push_rd), .push_data(push_data),
    .drain_en(drain_en), .regwrite(regwrite), .rd(rd), .write_data(write_data),
    .rs1(rs1), .rs2(rs2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every register-file write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && regwrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got rd=%0d data=%0h, required no write", rd, write_data);
      end else begin
        e = exp_q.pop_front();
        check("write_rd", 32'(rd), 32'(e.rd));
        check("write_data", write_data, e.data);
      end
      rf[rd] = write_data;
    end
  end

  // One push cycle: handshake must complete; regwrite checked at the same sample point.
  task automatic push_cycle(input logic [RS_WIDTH-1:0] r, input logic [31:0] d,
                            input logic exp_rw, input bit chk_cnt);
    push_valid = 1'b1;
    push_rd    = r;
    push_data  = d;
    @(negedge clk);
    check("push_ready", 32'(push_ready), 32'd1);
    check("regwrite", 32'(regwrite), 32'(exp_rw));
    if (chk_cnt) check("count_le1", 32'(count <= 3'd1), 32'd1);
    if (push_ready && r != '0) exp_q.push_back('{rd: r, data: d});
    @(posedge clk); #1;
    push_valid = 1'b0;
  endtask

  task automatic idle_cycle(input logic exp_rw);
    push_valid = 1'b0;
    @(negedge clk);
    check("idle_regwrite", 32'(regwrite), 32'(exp_rw));
    @(posedge clk); #1;
  endtask

  task automatic wait_empty(input int max_cyc);
    int n = 0;
    while (count != '0 && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", 32'(count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst = 1'b0; push_valid = 1'b0; push_rd = '0; push_data = '0;
    drain_en = 1'b0; rs1 = '0; rs2 = '0;

    // Reset / idle
    @(negedge clk);
    check("rst_regwrite", 32'(regwrite), 32'd0);
    check("rst_push_ready", 32'(push_ready), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_fwd1_hit", 32'(fwd1_hit), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_push_ready", 32'(push_ready), 32'd1);
    check("post_rst_count", 32'(count), 32'd0);
    @(posedge clk); #1;

    // Basic order: writes start one cycle after the first push, back to back
    drain_en = 1'b1;
    push_cycle(5'd5, 32'h11, 1'b0, 1'b0);
    push_cycle(5'd6, 32'h22, 1'b1, 1'b0);
    push_cycle(5'd7, 32'h33, 1'b1, 1'b0);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // Full / backpressure
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) push_cycle(5'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
    check("full_count", 32'(count), 32'd4);
    check("full_push_ready", 32'(push_ready), 32'd0);
    push_valid = 1'b1; push_rd = 5'd9; push_data = 32'h99;
    @(negedge clk);
    check("held_push_ready", 32'(push_ready), 32'd0);
    @(posedge clk); #1;
    check("held_count", 32'(count), 32'd4);
    drain_en = 1'b1;
    @(negedge clk);
    check("pop_while_full_ready", 32'(push_ready), 32'd0);
    @(posedge clk); #1;
    check("after_pop_count", 32'(count), 32'd3);
    check("after_pop_ready", 32'(push_ready), 32'd1);
    @(negedge clk);
    if (push_ready) exp_q.push_back('{rd: 5'd9, data: 32'h99});
    @(posedge clk); #1;
    push_valid = 1'b0;
    check("held_enqueued_count", 32'(count), 32'd3);
    wait_empty(20);

    // x0 drop
    push_cycle(5'd0, 32'hDEAD, 1'b0, 1'b0);
    check("x0_count", 32'(count), 32'd0);
    idle_cycle(1'b0);

    // Forwarding: youngest wins
    drain_en = 1'b0; rs1 = 5'd3; rs2 = 5'd4;
    push_cycle(5'd3, 32'hA, 1'b0, 1'b0);
    check("fwd1_data_first", fwd1_data, 32'hA);
    push_cycle(5'd3, 32'hB, 1'b0, 1'b0);
    check("fwd1_hit", 32'(fwd1_hit), 32'd1);
    check("fwd1_data_young", fwd1_data, 32'hB);
    check("fwd2_hit", 32'(fwd2_hit), 32'd0);
    check("fwd2_data", fwd2_data, 32'd0);
    rs2 = 5'd0;
    #1;
    check("fwd_x0_hit", 32'(fwd2_hit), 32'd0);
    drain_en = 1'b1;
    @(negedge clk);
    check("fwd_during_drain_hit", 32'(fwd1_hit), 32'd1);
    check("fwd_during_drain_data", fwd1_data, 32'hB);
    @(posedge clk); #1;
    wait_empty(20);
    check("rf_x3", rf[3], 32'hB);
    check("fwd_empty_hit", 32'(fwd1_hit), 32'd0);

    // Wrap-around with simultaneous push/pop, no gaps
    for (int i = 1; i <= 10; i++) push_cycle(5'(i), 32'(i * 2), (i > 1), 1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // Mid-queue reset clears state without a clock edge
    drain_en = 1'b0;
    push_cycle(5'd10, 32'h1, 1'b0, 1'b0);
    push_cycle(5'd11, 32'h2, 1'b0, 1'b0);
    push_cycle(5'd12, 32'h3, 1'b0, 1'b0);
    check("mid_count", 32'(count), 32'd3);
    drain_en = 1'b1;
    #1;
    check("mid_regwrite_pre", 32'(regwrite), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_regwrite", 32'(regwrite), 32'd0);
    check("mid_rst_ready", 32'(push_ready), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_post_ready", 32'(push_ready), 32'd1);
    check("mid_post_count", 32'(count), 32'd0);
    idle_cycle(1'b0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
